// File: rtl/frame_prefetch.sv
// Prefetches 4-bit gray pixels from the RP2040 framebuffer into a small FWFT FIFO for the VGA stage.
// Optional pixel capture counter is built when FRAME_PREFETCH_STATS_EN is defined.
module frame_prefetch #(
    parameter int DEPTH      = 8,
    parameter int STROBE_CYC = 2,
    parameter int SETTLE     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start_in,
    input  logic        pixel_req_in,
    output logic [3:0]  pixel_out,
    output logic        pixel_valid_out,
    output logic        underrun_out,
    output logic        fb_reset_out,
    output logic        fb_next_pixel_out,
    input  logic [3:0]  fb_pixel_in,
    output logic [15:0] pixel_count_out
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (STROBE_CYC > SETTLE) ? STROBE_CYC : SETTLE;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [AW:0]   DEPTH_C     = DEPTH[AW:0];
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_RST_HI,
        ST_NEXT_HI,
        ST_SETTLE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            primed_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d, next_count;
    logic [3:0]      mem [DEPTH];
    logic [3:0]      sync1_q, sync2_q;
    logic            underrun_q;
    logic            fb_reset_q, fb_next_q;
    logic            empty, push, pop;

    assign empty = (count_q == '0);
    // Frame start takes priority over any pop in the same cycle.
    assign pop   = pixel_req_in && !empty && !frame_start_in;

    assign next_count = count_q + (AW+1)'(1) - {{AW{1'b0}}, pop};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (frame_start_in) begin
            state_d = ST_RST_HI;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (primed_q && (count_q < DEPTH_C)) begin
                        state_d = ST_NEXT_HI;
                        cnt_d   = '0;
                    end
                end
                ST_RST_HI, ST_NEXT_HI: begin
                    if (cnt_q == STROBE_LAST) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = (next_count < DEPTH_C) ? ST_NEXT_HI : ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            underrun_q <= 1'b0;
            fb_reset_q <= 1'b0;
            fb_next_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= fb_pixel_in;
            sync2_q    <= sync1_q;
            // Strobes decode the next state so they are glitch-free flops.
            fb_reset_q <= (state_d == ST_RST_HI);
            fb_next_q  <= (state_d == ST_NEXT_HI);
            if (frame_start_in) begin
                primed_q   <= 1'b1;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                underrun_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_d;
                if (pixel_req_in && empty) underrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= sync2_q;
    end

    assign pixel_out         = empty ? 4'h0 : mem[rd_ptr_q];
    assign pixel_valid_out   = !empty;
    assign underrun_out      = underrun_q;
    assign fb_reset_out      = fb_reset_q;
    assign fb_next_pixel_out = fb_next_q;

`ifdef FRAME_PREFETCH_STATS_EN
    logic [15:0] pix_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
        end else if (frame_start_in) begin
            pix_cnt_q <= '0;
        end else if (push && (pix_cnt_q != 16'hFFFF)) begin
            pix_cnt_q <= pix_cnt_q + 16'd1;
        end
    end

    assign pixel_count_out = pix_cnt_q;
`else
    assign pixel_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_prefetch.sv
// Randomized self-checking bench for frame_prefetch with a behavioural RP2040 framebuffer model.
module tb_frame_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start_in = 1'b0;
    logic        pixel_req_in = 1'b0;
    logic [3:0]  pixel_out;
    logic        pixel_valid_out;
    logic        underrun_out;
    logic        fb_reset_out;
    logic        fb_next_pixel_out;
    logic [3:0]  fb_pixel_in = 4'h0;
    logic [15:0] pixel_count_out;

    int checks = 0;
    int failures = 0;

    frame_prefetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_start_in    (frame_start_in),
        .pixel_req_in      (pixel_req_in),
        .pixel_out         (pixel_out),
        .pixel_valid_out   (pixel_valid_out),
        .underrun_out      (underrun_out),
        .fb_reset_out      (fb_reset_out),
        .fb_next_pixel_out (fb_next_pixel_out),
        .fb_pixel_in       (fb_pixel_in),
        .pixel_count_out   (pixel_count_out)
    );

    always #5 clk = ~clk;

    // RP2040 model: rewinds on reset strobe, advances on next strobe, pixel k = base + k.
    logic [3:0] base = 4'h0;
    int idx = 0;
    int next_pulses = 0;
    int both_high = 0;
    logic prev_r = 1'b0;
    logic prev_n = 1'b0;

    function automatic logic [3:0] pat(input int k);
        return 4'(int'(base) + k);
    endfunction

    always @(negedge clk) begin
        if (fb_reset_out && !prev_r) begin
            idx = 0;
            next_pulses = 0;
        end else if (fb_next_pixel_out && !prev_n) begin
            idx = idx + 1;
            next_pulses = next_pulses + 1;
        end
        if (fb_reset_out && fb_next_pixel_out) both_high = both_high + 1;
        prev_r = fb_reset_out;
        prev_n = fb_next_pixel_out;
        fb_pixel_in = pat(idx);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int viol;
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++; if (pixel_out !== 4'h0) begin failures++; $display("FAIL reset_pixel got=%0h exp=0", pixel_out); end
        checks++; if (pixel_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", pixel_valid_out); end
        checks++; if (underrun_out !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%0b exp=0", underrun_out); end
        checks++; if (fb_reset_out !== 1'b0) begin failures++; $display("FAIL reset_fbrst got=%0b exp=0", fb_reset_out); end
        checks++; if (fb_next_pixel_out !== 1'b0) begin failures++; $display("FAIL reset_fbnext got=%0b exp=0", fb_next_pixel_out); end
        checks++; if (pixel_count_out !== 16'h0) begin failures++; $display("FAIL reset_count got=%0h exp=0", pixel_count_out); end
        rst_n = 1'b1;
        viol = 0;
        repeat (100) begin
            cyc();
            if (fb_reset_out || fb_next_pixel_out || pixel_valid_out) viol++;
        end
        checks++; if (viol !== 0) begin failures++; $display("FAIL idle_unprimed activity_cycles=%0d exp=0", viol); end
    endtask

    task automatic test_first_frame();
        base = 4'hA;
        cyc();
        frame_start_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            frame_start_in = 1'b0;
            checks++;
            if (fb_reset_out !== ((k <= 2) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL first_fbrst E+%0d got=%0b exp=%0b", k, fb_reset_out, (k <= 2));
            end
            checks++;
            if (pixel_valid_out !== ((k >= 7) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL first_valid E+%0d got=%0b exp=%0b", k, pixel_valid_out, (k >= 7));
            end
        end
        checks++; if (pixel_out !== 4'hA) begin failures++; $display("FAIL first_pixel got=%0h exp=a", pixel_out); end
    endtask

    task automatic test_fill();
        int bad;
        base = 4'($urandom);
        cyc();
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        bad = 0;
        repeat (120) begin
            cyc();
            if (pixel_valid_out && pixel_out !== pat(0)) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL fill_head bad_cycles=%0d exp=0", bad); end
        checks++; if (next_pulses !== 7) begin failures++; $display("FAIL fill_captures got=%0d exp=8", next_pulses + 1); end
        checks++; if ({fb_reset_out, fb_next_pixel_out} !== 2'b00) begin failures++; $display("FAIL fill_strobes got=%0b%0b exp=00", fb_reset_out, fb_next_pixel_out); end
        pixel_req_in = 1'b1;
        cyc();
        pixel_req_in = 1'b0;
        checks++; if (pixel_out !== pat(1)) begin failures++; $display("FAIL fill_pop_next got=%0h exp=%0h", pixel_out, pat(1)); end
        repeat (40) cyc();
        checks++; if (next_pulses !== 8) begin failures++; $display("FAIL refill_pulses got=%0d exp=8", next_pulses); end
        checks++; if (next_pulses + 1 - 1 !== 8) begin failures++; $display("FAIL refill_occupancy got=%0d exp=8", next_pulses); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (pixel_out !== pat(k)) begin failures++; $display("FAIL drain_order k=%0d got=%0h exp=%0h", k, pixel_out, pat(k)); end
            pixel_req_in = 1'b1;
            cyc();
            pixel_req_in = 1'b0;
        end
    endtask

    task automatic test_underrun();
        int pops;
        base = 4'($urandom);
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        pixel_req_in = 1'b1;
        checks++; if (underrun_out !== 1'b0) begin failures++; $display("FAIL und_cleared got=%0b exp=0", underrun_out); end
        pops = 0;
        for (int t = 2; t < 62; t++) begin
            cyc();
            checks++; if (underrun_out !== 1'b1) begin failures++; $display("FAIL und_sticky t=%0d got=%0b exp=1", t, underrun_out); end
            if (pixel_valid_out) begin
                checks++; if (pixel_out !== pat(pops)) begin failures++; $display("FAIL und_data n=%0d got=%0h exp=%0h", pops, pixel_out, pat(pops)); end
                pops++;
            end
        end
        checks++; if (pops < 8) begin failures++; $display("FAIL und_throughput got=%0d exp>=8", pops); end
        pixel_req_in = 1'b0;
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        repeat (3) begin
            checks++; if (underrun_out !== 1'b0) begin failures++; $display("FAIL und_clear_fs got=%0b exp=0", underrun_out); end
            cyc();
        end
    endtask

    task automatic test_frame_abort();
        int guard;
        base = 4'($urandom);
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        guard = 0;
        while (!(next_pulses == 5 && fb_next_pixel_out) && guard < 200) begin
            cyc();
            guard++;
        end
        checks++; if (guard >= 200) begin failures++; $display("FAIL abort_wait timeout got=%0d exp<200", guard); end
        checks++; if (pixel_out !== pat(0)) begin failures++; $display("FAIL abort_head got=%0h exp=%0h", pixel_out, pat(0)); end
        base = 4'($urandom);
        frame_start_in = 1'b1;
        pixel_req_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            frame_start_in = 1'b0;
            pixel_req_in = 1'b0;
            if (k == 1) begin
                checks++; if (pixel_valid_out !== 1'b0) begin failures++; $display("FAIL abort_flush got=%0b exp=0", pixel_valid_out); end
                checks++; if (fb_next_pixel_out !== 1'b0) begin failures++; $display("FAIL abort_next_drop got=%0b exp=0", fb_next_pixel_out); end
                checks++; if (underrun_out !== 1'b0) begin failures++; $display("FAIL abort_underrun got=%0b exp=0", underrun_out); end
            end
            checks++;
            if (fb_reset_out !== ((k <= 2) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL abort_fbrst E+%0d got=%0b exp=%0b", k, fb_reset_out, (k <= 2));
            end
        end
        checks++; if (pixel_valid_out !== 1'b1) begin failures++; $display("FAIL abort_refetch_valid got=%0b exp=1", pixel_valid_out); end
        checks++; if (pixel_out !== pat(0)) begin failures++; $display("FAIL abort_refetch_pixel got=%0h exp=%0h", pixel_out, pat(0)); end
    endtask

    task automatic test_random();
        int pops;
        int bad;
        base = 4'($urandom);
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        pops = 0;
        bad = 0;
        repeat (400) begin
            cyc();
            checks++;
            if (pixel_out !== (pixel_valid_out ? pat(pops) : 4'h0)) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL rand_data n=%0d got=%0h exp=%0h", pops, pixel_out, pixel_valid_out ? pat(pops) : 4'h0);
            end
            pixel_req_in = ($urandom_range(0, 99) < 40);
            if (pixel_req_in && pixel_valid_out) pops++;
        end
        pixel_req_in = 1'b0;
        repeat (80) cyc();
        checks++; if (next_pulses + 1 - pops !== 8) begin failures++; $display("FAIL rand_occupancy got=%0d exp=8", next_pulses + 1 - pops); end
        checks++; if (pixel_out !== pat(pops)) begin failures++; $display("FAIL rand_head got=%0h exp=%0h", pixel_out, pat(pops)); end
`ifdef FRAME_PREFETCH_STATS_EN
        checks++; if (pixel_count_out !== 16'(next_pulses + 1)) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", pixel_count_out, next_pulses + 1); end
`else
        checks++; if (pixel_count_out !== 16'h0) begin failures++; $display("FAIL rand_count got=%0d exp=0", pixel_count_out); end
`endif
    endtask

    task automatic test_stats();
        int guard;
        logic [15:0] exp20;
`ifdef FRAME_PREFETCH_STATS_EN
        exp20 = 16'd20;
`else
        exp20 = 16'd0;
`endif
        base = 4'($urandom);
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        checks++; if (pixel_count_out !== 16'h0) begin failures++; $display("FAIL stats_clear got=%0d exp=0", pixel_count_out); end
        pixel_req_in = 1'b1;
        guard = 0;
        while (!(next_pulses == 20 && fb_next_pixel_out) && guard < 400) begin
            cyc();
            guard++;
        end
        pixel_req_in = 1'b0;
        checks++; if (guard >= 400) begin failures++; $display("FAIL stats_wait timeout got=%0d exp<400", guard); end
        checks++; if (pixel_count_out !== exp20) begin failures++; $display("FAIL stats_count20 got=%0d exp=%0d", pixel_count_out, exp20); end
    endtask

    task automatic test_async_reset();
        base = 4'($urandom);
        frame_start_in = 1'b1;
        cyc();
        frame_start_in = 1'b0;
        repeat (20) cyc();
        checks++; if (pixel_valid_out !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%0b exp=1", pixel_valid_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pixel_valid_out !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0b exp=0", pixel_valid_out); end
        checks++; if (pixel_out !== 4'h0) begin failures++; $display("FAIL areset_pixel got=%0h exp=0", pixel_out); end
        checks++; if ({fb_reset_out, fb_next_pixel_out} !== 2'b00) begin failures++; $display("FAIL areset_strobes got=%0b%0b exp=00", fb_reset_out, fb_next_pixel_out); end
        cyc();
        rst_n = 1'b1;
        repeat (20) cyc();
        checks++; if ({fb_reset_out, fb_next_pixel_out, pixel_valid_out} !== 3'b000) begin failures++; $display("FAIL areset_unprimed got=%0b exp=000", {fb_reset_out, fb_next_pixel_out, pixel_valid_out}); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_fill();
        test_underrun();
        test_frame_abort();
        test_random();
        test_stats();
        test_async_reset();
        checks++; if (both_high !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", both_high); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
